// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter that shares one execute-stage ALU
// Registers the granted operands into the ALU and returns the result over a valid/ready response.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              req_valid_i,
  output logic [1:0]              req_ready_o,
  input  logic [2*OP_WIDTH-1:0]   req_op_i,
  input  logic [2*DATA_WIDTH-1:0] req_a_i,
  input  logic [2*DATA_WIDTH-1:0] req_b_i,
  output logic [1:0]              rsp_valid_o,
  input  logic [1:0]              rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_result_o,
  output logic                    rsp_branch_o,
  output logic [OP_WIDTH-1:0]     alu_op_o,
  output logic [DATA_WIDTH-1:0]   alu_a_o,
  output logic [DATA_WIDTH-1:0]   alu_b_o,
  input  logic [DATA_WIDTH-1:0]   alu_result_i,
  input  logic                    alu_branch_i
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state, state_nxt;
  logic                  rr_ptr;
  logic                  gnt_q;
  logic [OP_WIDTH-1:0]   op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic                  br_q;
  logic                  gnt;
  logic                  hs;
  logic                  is_branch;

  // A lone valid requester always wins; ties go to the pointer or to req0.
  always_comb begin
    gnt = ~req_valid_i[0];
    if (FIXED_PRIO == 0 && (&req_valid_i)) begin
      gnt = rr_ptr;
    end
  end

  always_comb begin
    req_ready_o = 2'b00;
    if (state == IDLE && (|req_valid_i) && !rst_i) begin
      req_ready_o = gnt ? 2'b10 : 2'b01;
    end
  end

  assign hs = |(req_valid_i & req_ready_o);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready_i[gnt_q]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Branch opcodes occupy the top quarter of the opcode space; their ALU result is undefined.
  assign is_branch = (op_q[OP_WIDTH-1:OP_WIDTH-2] == 2'b11);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
      gnt_q  <= 1'b0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      br_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        gnt_q  <= gnt;
        rr_ptr <= ~gnt;
        op_q   <= gnt ? req_op_i[2*OP_WIDTH-1:OP_WIDTH]     : req_op_i[OP_WIDTH-1:0];
        a_q    <= gnt ? req_a_i[2*DATA_WIDTH-1:DATA_WIDTH]  : req_a_i[DATA_WIDTH-1:0];
        b_q    <= gnt ? req_b_i[2*DATA_WIDTH-1:DATA_WIDTH]  : req_b_i[DATA_WIDTH-1:0];
      end
      if (state == EXEC) begin
        res_q <= is_branch ? '0 : alu_result_i;
        br_q  <= is_branch ? alu_branch_i : 1'b0;
      end
    end
  end

  // Operand registers only change on a grant, so the ALU inputs stay quiet between ops.
  assign alu_op_o     = op_q;
  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign rsp_result_o = res_q;
  assign rsp_branch_o = br_q;
  assign rsp_valid_o  = (state == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
// Round-robin instance plus a fixed-priority instance, each driving a small ALU model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a, req_b;
  logic [31:0] rsp_result, alu_a, alu_b, alu_result;
  logic        rsp_branch, alu_branch;
  logic [3:0]  alu_op;

  logic [1:0]  f_valid, f_ready, f_rsp_valid, f_rsp_ready;
  logic [7:0]  f_op;
  logic [63:0] f_a, f_b;
  logic [31:0] f_result, f_alu_a, f_alu_b, f_alu_result;
  logic        f_branch, f_alu_branch;
  logic [3:0]  f_alu_op;

  int checks = 0;
  int errors = 0;

  logic [31:0] res;
  logic        br;
  int          lat;
  logic        flag;
  logic [1:0]  eg;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4), .FIXED_PRIO(0)) dut_rr (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_branch_o(rsp_branch),
    .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_result_i(alu_result), .alu_branch_i(alu_branch)
  );

  alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4), .FIXED_PRIO(1)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(f_valid), .req_ready_o(f_ready),
    .req_op_i(f_op), .req_a_i(f_a), .req_b_i(f_b),
    .rsp_valid_o(f_rsp_valid), .rsp_ready_i(f_rsp_ready),
    .rsp_result_o(f_result), .rsp_branch_o(f_branch),
    .alu_op_o(f_alu_op), .alu_a_o(f_alu_a), .alu_b_o(f_alu_b),
    .alu_result_i(f_alu_result), .alu_branch_i(f_alu_branch)
  );

  function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return {1'bx, 32'h0};
      4'b0001: return {1'bx, a + b};
      4'b0010: return {1'bx, a - b};
      4'b1100: return {(a == b), {32{1'bx}}};
      4'b1101: return {(a != b), {32{1'bx}}};
      default: return {1'bx, a ^ b};
    endcase
  endfunction

  always_comb {alu_branch, alu_result} = alu_ref(alu_op, alu_a, alu_b);
  always_comb {f_alu_branch, f_alu_result} = alu_ref(f_alu_op, f_alu_a, f_alu_b);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready0();
    int n = 0;
    @(negedge clk);
    while (req_ready == 2'b00 && n < 20) begin @(negedge clk); n++; end
    chk("wait_ready0_bound", 64'(n < 20), 64'd1);
  endtask

  task automatic wait_rsp0();
    int n = 0;
    @(negedge clk);
    while (rsp_valid == 2'b00 && n < 20) begin @(negedge clk); n++; end
    chk("wait_rsp0_bound", 64'(n < 20), 64'd1);
  endtask

  task automatic wait_ready_f();
    int n = 0;
    @(negedge clk);
    while (f_ready == 2'b00 && n < 20) begin @(negedge clk); n++; end
    chk("wait_ready_f_bound", 64'(n < 20), 64'd1);
  endtask

  task automatic wait_rsp_f();
    int n = 0;
    @(negedge clk);
    while (f_rsp_valid == 2'b00 && n < 20) begin @(negedge clk); n++; end
    chk("wait_rsp_f_bound", 64'(n < 20), 64'd1);
  endtask

  // Lat counts negedges after the accepting edge; 2 means the response shows in cycle N+2.
  task automatic run_op(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] o_res, output logic o_br, output int o_lat);
    int n = 0;
    req_op[r*4 +: 4]  = op;
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
    req_valid[r]      = 1'b1;
    rsp_ready         = 2'b11;
    @(negedge clk);
    while (!req_ready[r] && n < 20) begin @(negedge clk); n++; end
    chk("run_op_accept_bound", 64'(n < 20), 64'd1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    o_lat = 0;
    do begin @(negedge clk); o_lat++; end while (!rsp_valid[r] && o_lat < 20);
    o_res = rsp_result;
    o_br  = rsp_branch;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    f_valid = '0; f_op = '0; f_a = '0; f_b = '0; f_rsp_ready = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_result", rsp_result, 32'h0);
    chk("rst_branch", rsp_branch, 1'b0);
    chk("rst_alu_op", alu_op, 4'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_f_rsp_valid", f_rsp_valid, 2'b00);

    // Single add with exact latency
    @(posedge clk); #1;
    req_op[3:0] = 4'b0001; req_a[31:0] = 32'd5; req_b[31:0] = 32'd7;
    req_valid = 2'b01; rsp_ready = 2'b11;
    @(negedge clk);
    chk("t1_ready", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    chk("t1_exec_no_rsp", rsp_valid, 2'b00);
    chk("t1_alu_op", alu_op, 4'b0001);
    chk("t1_alu_a", alu_a, 32'd5);
    chk("t1_alu_b", alu_b, 32'd7);
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_result", rsp_result, 32'd12);
    chk("t1_branch", rsp_branch, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_back_idle", rsp_valid, 2'b00);

    // Round-robin contention: pointer now favours req1
    @(posedge clk); #1;
    req_op = {4'b0010, 4'b0010};
    req_a  = {32'd3, 32'd20};
    req_b  = {32'd10, 32'd4};
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      eg = (k % 2 == 0) ? 2'b10 : 2'b01;
      wait_ready0();
      chk("t2_grant", req_ready, eg);
      @(posedge clk);
      wait_rsp0();
      chk("t2_rsp_valid", rsp_valid, eg);
      chk("t2_result", rsp_result, (eg == 2'b10) ? 32'hFFFFFFF9 : 32'd16);
      @(posedge clk); #1;
    end
    req_valid = 2'b00;

    // Branch ops: result forced to 0, branch from the ALU
    run_op(1, 4'b1100, 32'h1234, 32'h1234, res, br, lat);
    chk("t3_beq_taken_br", br, 1'b1);
    chk("t3_beq_taken_res", res, 32'h0);
    chk("t3_beq_lat", lat, 2);
    run_op(1, 4'b1100, 32'd1, 32'd2, res, br, lat);
    chk("t3_beq_not_br", br, 1'b0);
    chk("t3_beq_not_res", res, 32'h0);
    run_op(0, 4'b0000, 32'd9, 32'd9, res, br, lat);
    chk("t3_op0_res", res, 32'h0);
    chk("t3_op0_br", br, 1'b0);
    run_op(0, 4'b1101, 32'd1, 32'd2, res, br, lat);
    chk("t3_bne_br", br, 1'b1);
    chk("t3_bne_res", res, 32'h0);

    // Backpressure; req1 ready high must be ignored while req0 owns the response
    req_op[3:0] = 4'b0001; req_a[31:0] = 32'd1; req_b[31:0] = 32'd2;
    req_valid = 2'b01; rsp_ready = 2'b10;
    wait_ready0();
    chk("t4_grant0", req_ready, 2'b01);
    @(posedge clk); #1;
    req_op[7:4] = 4'b0001; req_a[63:32] = 32'd1; req_b[63:32] = 32'd1;
    req_valid = 2'b11;
    @(negedge clk);
    flag = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid !== 2'b01 || rsp_result !== 32'd3 || req_ready !== 2'b00) flag = 1'b0;
    end
    chk("t4_stable", flag, 1'b1);
    @(posedge clk); #1 rsp_ready = 2'b01;
    @(negedge clk);
    chk("t4_last_rsp_valid", rsp_valid, 2'b01);
    chk("t4_last_ready", req_ready, 2'b00);
    @(negedge clk);
    chk("t4_resume_grant1", req_ready, 2'b10);
    @(posedge clk); #1 req_valid = 2'b00; rsp_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("t4_req1_rsp_valid", rsp_valid, 2'b10);
    chk("t4_req1_result", rsp_result, 32'd2);
    @(posedge clk); #1;

    // Fixed priority: req0 always wins until it drops
    f_op = {4'b0001, 4'b0001};
    f_a  = {32'd100, 32'd1};
    f_b  = {32'd200, 32'd2};
    f_valid = 2'b11; f_rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) f_valid = 2'b10;
      eg = (k == 3) ? 2'b10 : 2'b01;
      wait_ready_f();
      chk("t5_grant", f_ready, eg);
      @(posedge clk);
      wait_rsp_f();
      chk("t5_rsp_valid", f_rsp_valid, eg);
      chk("t5_result", f_result, (k == 3) ? 32'd300 : 32'd3);
      @(posedge clk); #1;
    end
    f_valid = 2'b00;

    // Reset during EXEC
    req_op[3:0] = 4'b0001; req_a[31:0] = 32'd2; req_b[31:0] = 32'd3;
    req_valid = 2'b01; rsp_ready = 2'b11;
    wait_ready0();
    @(posedge clk); #1 rst = 1'b1; req_valid = 2'b00;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6e_ready", req_ready, 2'b00);
    chk("t6e_rsp_valid", rsp_valid, 2'b00);
    chk("t6e_result", rsp_result, 32'h0);
    chk("t6e_alu_op", alu_op, 4'h0);
    chk("t6e_alu_a", alu_a, 32'h0);
    flag = 1'b0;
    repeat (3) begin @(negedge clk); if (rsp_valid !== 2'b00) flag = 1'b1; end
    chk("t6e_no_rsp", flag, 1'b0);

    // Reset during RESP
    @(posedge clk); #1;
    req_op[3:0] = 4'b0001; req_a[31:0] = 32'd4; req_b[31:0] = 32'd4;
    req_valid = 2'b01; rsp_ready = 2'b00;
    wait_ready0();
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("t6r_pre_rsp_valid", rsp_valid, 2'b01);
    chk("t6r_pre_result", rsp_result, 32'd8);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6r_rsp_valid", rsp_valid, 2'b00);
    chk("t6r_result", rsp_result, 32'h0);
    chk("t6r_branch", rsp_branch, 1'b0);
    chk("t6r_alu_b", alu_b, 32'h0);
    @(posedge clk); #1;
    run_op(0, 4'b0001, 32'd4, 32'd5, res, br, lat);
    chk("t6_after_result", res, 32'd9);
    chk("t6_after_branch", br, 1'b0);
    chk("t6_after_lat", lat, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
